// File: rtl/lc3_arb_pkg.sv
// rtl/lc3_arb_pkg.sv - shared types for the LC-3 two-port memory arbiter.
package lc3_arb_pkg;

    localparam int ARB_PORTS = 2;
    localparam int ARB_AW    = 16;
    localparam int ARB_DW    = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/lc3_arb_pick.sv
// rtl/lc3_arb_pick.sv - combinational winner selection for the memory arbiter.
// At most one bit of gnt is ever set; locks are tied low unless LC3_ARB_LOCK_EN.
module lc3_arb_pick
    import lc3_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic [ARB_PORTS-1:0] reqs,
    input  logic [ARB_PORTS-1:0] locks,
    input  arb_state_t           state,
    input  logic [7:0]           burst_cnt,
    input  logic                 last_owner,
    output logic [ARB_PORTS-1:0] gnt,
    output arb_state_t           next_state
);

    logic owner;
    logic other;
    logic keep;

    always_comb begin
        gnt        = '0;
        owner      = (state == ARB_OWN1);
        other      = ~owner;
        keep       = 1'b0;
        next_state = ARB_IDLE;
        case (state)
            ARB_OWN0, ARB_OWN1: begin
                // A locked owner keeps the memory regardless of the burst budget.
                keep = reqs[owner] &&
                       (!reqs[other] || locks[owner] || (burst_cnt < 8'(BURST_MAX)));
                if (keep)
                    gnt[owner] = 1'b1;
                else if (reqs[other])
                    gnt[other] = 1'b1;
            end
            default: begin
                if (&reqs)
                    gnt[~last_owner] = 1'b1;
                else
                    gnt = reqs;
            end
        endcase
        if (gnt[0])
            next_state = ARB_OWN0;
        else if (gnt[1])
            next_state = ARB_OWN1;
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - burst-limited round-robin arbiter for a shared single-port memory.
// Define LC3_ARB_LOCK_EN to add lock0/lock1 for atomic owner bursts.
module lc3_mem_arbiter
    import lc3_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
`ifdef LC3_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t           arb_state;
    arb_state_t           next_state;
    logic [7:0]           burst_cnt;
    logic                 last_owner;
    logic                 rd_pend;
    logic                 rd_tag;
    logic [ARB_PORTS-1:0] gnt;
    logic [ARB_PORTS-1:0] locks;
    logic                 same_owner;

`ifdef LC3_ARB_LOCK_EN
    assign locks = {lock1, lock0};
`else
    assign locks = '0;
`endif

    lc3_arb_pick #(.BURST_MAX(BURST_MAX)) u_pick (
        .reqs       ({req1, req0}),
        .locks      (locks),
        .state      (arb_state),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .gnt        (gnt),
        .next_state (next_state)
    );

    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    assign mem_en = |gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt[1]) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // A grant that continues the current ownership extends the burst; any other grant starts one.
    assign same_owner = (gnt[0] && (arb_state == ARB_OWN0)) ||
                        (gnt[1] && (arb_state == ARB_OWN1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_state  <= ARB_IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            arb_state <= next_state;
            if (!mem_en)
                burst_cnt <= '0;
            else if (!same_owner)
                burst_cnt <= 8'd1;
            else if (burst_cnt < 8'(BURST_MAX))
                burst_cnt <= burst_cnt + 8'd1;
            if (mem_en) begin
                last_owner <= gnt[1];
                rd_tag     <= gnt[1];
            end
            rd_pend <= mem_en & ~mem_we;
        end
    end

    assign rvalid0 = rd_pend & ~rd_tag;
    assign rvalid1 = rd_pend & rd_tag;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - self-checking bench for lc3_mem_arbiter (LC3_ARB_LOCK_EN aware).
module tb_lc3_mem_arbiter;
    import lc3_arb_pkg::*;

    localparam int BURST_MAX = 4;
`ifdef LC3_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic lock0 = 0, lock1 = 0;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 0;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.AW(16), .DW(16), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef LC3_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory behind the arbiter, one-cycle read latency.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Reference model: current owner (-1 none), length of its run, last winner, shadow memory.
    int          m_owner, m_run, m_last, last_g;
    logic [15:0] ref_mem [0:255];
    logic        exp_pv, exp_pt;
    logic [15:0] exp_pd;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1; exp_pv = 0; exp_pt = 0; exp_pd = 0; last_g = -1;
    endtask

    function automatic int predict(logic r0, logic r1, logic l0, logic l1);
        logic [1:0] r, l;
        r = {r1, r0};
        l = {l1, l0};
        if (r == 2'b00) return -1;
        if (m_owner < 0) begin
            if (r == 2'b11) return 1 - m_last;
            return r[0] ? 0 : 1;
        end
        if (r[m_owner] && (!r[1-m_owner] || (LOCK_EN && l[m_owner]) || m_run < BURST_MAX))
            return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic step(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic l0, input logic r1, input logic w1, input logic [15:0] a1,
                        input logic [15:0] d1, input logic l1);
        int g;
        logic gw;
        logic [15:0] ga, gd;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #1;
        g  = predict(r0, r1, l0, l1);
        gw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
        ga = (g == 0) ? a0 : (g == 1) ? a1 : 16'h0;
        gd = (g == 0) ? d0 : (g == 1) ? d1 : 16'h0;
        check("gnt0", gnt0, g == 0);
        check("gnt1", gnt1, g == 1);
        check("mem_en", mem_en, g >= 0);
        check("mem_we", mem_we, gw);
        check("mem_addr", mem_addr, ga);
        check("mem_wdata", mem_wdata, gd);
        check("rvalid0", rvalid0, exp_pv && !exp_pt);
        check("rvalid1", rvalid1, exp_pv && exp_pt);
        if (exp_pv) check("rdata", exp_pt ? rdata1 : rdata0, exp_pd);
        exp_pv = (g >= 0) && !gw;
        exp_pt = (g == 1);
        exp_pd = ref_mem[ga[7:0]];
        if (g >= 0 && gw) ref_mem[ga[7:0]] = gd;
        if (g < 0) begin
            m_owner = -1; m_run = 0;
        end else begin
            if (g == m_owner) m_run++;
            else begin m_owner = g; m_run = 1; end
            m_last = g;
        end
        last_g = g;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic     r0;
        arb_req_t q0;
        logic     r1;
        arb_req_t q1;
        logic     g0, g1, v0, v1;
        logic [15:0] rd;
    } vec_t;

    function automatic vec_t mk(logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
                                logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
                                logic g0, logic g1, logic v0, logic v1, logic [15:0] rd);
        vec_t v;
        v.r0 = r0; v.q0 = '{we: w0, addr: a0, wdata: d0};
        v.r1 = r1; v.q1 = '{we: w1, addr: a1, wdata: d1};
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    vec_t tbl [17];

    logic        p0, pw0, p1, pw1;
    logic [15:0] pa0, pd0, pa1, pd1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 16'h0101) ^ 16'hC3A5;
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'hC3A5;
        end
        mem[8'h20] = 16'hAAAA; ref_mem[8'h20] = 16'hAAAA;
        mem[8'h21] = 16'h5555; ref_mem[8'h21] = 16'h5555;
        mem[8'h30] = 16'h3030; ref_mem[8'h30] = 16'h3030;
        mem[8'h31] = 16'h3131; ref_mem[8'h31] = 16'h3131;
        model_reset();

        // Contention burst, idle, port-0 write/read, then alternating-port reads.
        tbl[0]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 1, 0, 16'h3030);
        tbl[2]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 1, 0, 16'h3030);
        tbl[3]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 1, 0, 16'h3030);
        tbl[4]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 0, 1, 1, 0, 16'h3030);
        tbl[5]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 0, 1, 0, 1, 16'h3131);
        tbl[6]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 0, 1, 0, 1, 16'h3131);
        tbl[7]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 0, 1, 0, 1, 16'h3131);
        tbl[8]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 0, 1, 16'h3131);
        tbl[9]  = mk(1, 0, 16'h30, 0, 1, 0, 16'h31, 0, 1, 0, 1, 0, 16'h3030);
        tbl[10] = mk(0, 0, 16'h00, 0, 0, 0, 16'h00, 0, 0, 0, 1, 0, 16'h3030);
        tbl[11] = mk(1, 1, 16'h10, 16'h1234, 0, 0, 16'h00, 0, 1, 0, 0, 0, 16'h0000);
        tbl[12] = mk(1, 0, 16'h10, 0, 0, 0, 16'h00, 0, 1, 0, 0, 0, 16'h0000);
        tbl[13] = mk(1, 0, 16'h20, 0, 0, 0, 16'h00, 0, 1, 0, 1, 0, 16'h1234);
        tbl[14] = mk(0, 0, 16'h00, 0, 1, 0, 16'h21, 0, 0, 1, 1, 0, 16'hAAAA);
        tbl[15] = mk(0, 0, 16'h00, 0, 0, 0, 16'h00, 0, 0, 0, 0, 1, 16'h5555);
        tbl[16] = mk(0, 0, 16'h00, 0, 0, 0, 16'h00, 0, 0, 0, 0, 0, 16'h0000);

        // Reset state, then ten idle cycles.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) idle();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r0, tbl[i].q0.we, tbl[i].q0.addr, tbl[i].q0.wdata, 0,
                 tbl[i].r1, tbl[i].q1.we, tbl[i].q1.addr, tbl[i].q1.wdata, 0);
            check($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
            check($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
            check($sformatf("tbl%0d_rvalid0", i), rvalid0, tbl[i].v0);
            check($sformatf("tbl%0d_rvalid1", i), rvalid1, tbl[i].v1);
            if (tbl[i].v0) check($sformatf("tbl%0d_rdata0", i), rdata0, tbl[i].rd);
            if (tbl[i].v1) check($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].rd);
        end

        // Randomized traffic; each port holds its access until granted.
        p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; pw0 = 1'($urandom_range(0, 1));
                pa0 = 16'h0040 + 16'($urandom_range(0, 15)); pd0 = 16'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; pw1 = 1'($urandom_range(0, 1));
                pa1 = 16'h0040 + 16'($urandom_range(0, 15)); pd1 = 16'($urandom);
            end
            step(p0, pw0, pa0, pd0, 0, p1, pw1, pa1, pd1, 0);
            if (last_g == 0) p0 = 0;
            if (last_g == 1) p1 = 0;
        end
        idle();
        idle();

        // Reset lands on the edge that would capture a granted port-1 read.
        step(0, 0, 0, 0, 0, 1, 0, 16'h21, 0, 0);
        check("rstrd_gnt1", gnt1, 1);
        reset = 1'b1;
        req1  = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rstrd_rvalid1_in_reset", rvalid1, 0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        check("rstrd_rvalid1_after", rvalid1, 0);
        step(1, 0, 16'h30, 0, 0, 1, 0, 16'h31, 0, 0);
        check("rstrd_first_gnt0", gnt0, 1);
        idle();
        idle();

`ifdef LC3_ARB_LOCK_EN
        step(0, 0, 0, 0, 0, 1, 0, 16'h31, 0, 1);
        check("lock_gnt1_0", gnt1, 1);
        for (int k = 1; k < 10; k++) begin
            step(1, 0, 16'h30, 0, 0, 1, 0, 16'h31, 0, 1);
            check($sformatf("lock_gnt1_%0d", k), gnt1, 1);
        end
        step(1, 0, 16'h30, 0, 0, 1, 0, 16'h31, 0, 0);
        check("lock_release_gnt0", gnt0, 1);
        idle();
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
